// File: rtl/demux_stream.sv
// demux_stream: three-way valid/ready stream demultiplexer.
//
// Each packet goes to output channel u, v or w. The route is decoded from
// s0/s1 on the first beat: s1=1 selects w, s1=0/s0=1 selects v, and
// s1=0/s0=0 selects u. The route is then held until the packet's last beat.
// Each channel is a one-entry registered slot, so every output comes
// straight from a flop.
//
// Parameters:
//   WIDTH            payload bits per beat (1..32)
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   input stream
//   s0, s1           route select, sampled on a packet's first beat only
//   x_data/x_last/x_valid (out), x_ready (in)   channel x in {u, v, w}
// Optional feature (macro DEMUX_STREAM_COUNT_EN):
//   u_pkts/v_pkts/w_pkts  8-bit wrapping count of last beats leaving each channel
module demux_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             s0,
  input  logic             s1,
  output logic             in_ready,
  output logic [WIDTH-1:0] u_data,
  output logic             u_last,
  output logic             u_valid,
  input  logic             u_ready,
  output logic [WIDTH-1:0] v_data,
  output logic             v_last,
  output logic             v_valid,
  input  logic             v_ready,
  output logic [WIDTH-1:0] w_data,
  output logic             w_last,
  output logic             w_valid,
  input  logic             w_ready
`ifdef DEMUX_STREAM_COUNT_EN
  ,
  output logic [7:0]       u_pkts,
  output logic [7:0]       v_pkts,
  output logic [7:0]       w_pkts
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [1:0] {
    ROUTE_U = 2'd0,
    ROUTE_V = 2'd1,
    ROUTE_W = 2'd2
  } route_t;

  state_t state, state_nxt;
  route_t route_q, route_nxt;
  route_t live_route, target;
  logic   accept;
  logic   target_free;

  // Live decode of the select inputs; s1 takes priority over s0.
  always_comb begin
    live_route = ROUTE_U;
    if (s1) begin
      live_route = ROUTE_W;
    end else if (s0) begin
      live_route = ROUTE_V;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      route_q <= ROUTE_U;
    end else begin
      state   <= state_nxt;
      route_q <= route_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    route_nxt = route_q;
    case (state)
      IDLE: begin
        // A single-beat packet never opens a packet; only multi-beat
        // packets latch their route.
        if (accept && !in_last) begin
          state_nxt = BUSY;
          route_nxt = live_route;
        end
      end
      BUSY: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: target selection and input handshake.
  // A slot can take a beat when it is empty or is being drained on this same
  // edge, which gives full throughput with a one-entry slot.
  always_comb begin
    target      = (state == BUSY) ? route_q : live_route;
    target_free = 1'b0;
    case (target)
      ROUTE_U: target_free = !u_valid || u_ready;
      ROUTE_V: target_free = !v_valid || v_ready;
      ROUTE_W: target_free = !w_valid || w_ready;
      default: target_free = 1'b0;
    endcase
    in_ready = !rst && target_free;
    accept   = in_valid && in_ready;
  end

  // Channel slots. A load takes precedence over a drain so that fill and
  // drain on the same edge leave the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_data  <= '0;
      u_last  <= 1'b0;
      u_valid <= 1'b0;
    end else if (accept && (target == ROUTE_U)) begin
      u_data  <= in_data;
      u_last  <= in_last;
      u_valid <= 1'b1;
    end else if (u_valid && u_ready) begin
      u_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_data  <= '0;
      v_last  <= 1'b0;
      v_valid <= 1'b0;
    end else if (accept && (target == ROUTE_V)) begin
      v_data  <= in_data;
      v_last  <= in_last;
      v_valid <= 1'b1;
    end else if (v_valid && v_ready) begin
      v_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_data  <= '0;
      w_last  <= 1'b0;
      w_valid <= 1'b0;
    end else if (accept && (target == ROUTE_W)) begin
      w_data  <= in_data;
      w_last  <= in_last;
      w_valid <= 1'b1;
    end else if (w_valid && w_ready) begin
      w_valid <= 1'b0;
    end
  end

`ifdef DEMUX_STREAM_COUNT_EN
  // Packet counters: one count per last beat leaving the channel; wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_pkts <= '0;
      v_pkts <= '0;
      w_pkts <= '0;
    end else begin
      if (u_valid && u_ready && u_last) u_pkts <= u_pkts + 8'd1;
      if (v_valid && v_ready && v_last) v_pkts <= v_pkts + 8'd1;
      if (w_valid && w_ready && w_last) w_pkts <= w_pkts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Testbench for demux_stream: directed scenarios plus randomized traffic,
// checked cycle by cycle against a packet-level scoreboard (one expected-beat
// queue per channel).
module tb_demux_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         s0 = 1'b0;
  logic         s1 = 1'b0;
  logic         in_ready;
  logic [W-1:0] u_data, v_data, w_data;
  logic         u_last, v_last, w_last;
  logic         u_valid, v_valid, w_valid;
  logic         u_ready = 1'b1;
  logic         v_ready = 1'b1;
  logic         w_ready = 1'b1;
`ifdef DEMUX_STREAM_COUNT_EN
  logic [7:0]   u_pkts, v_pkts, w_pkts;
  logic [7:0]   cnt [3];
`endif

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: beats accepted but not yet departed, per channel, as {last,data}.
  logic [W:0] q [3][$];
  bit         pkt_open = 1'b0;
  int         pkt_ch = 0;
  bit         mon_en = 1'b0;
  bit         rnd_ready = 1'b0;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .s0(s0), .s1(s1), .in_ready(in_ready),
    .u_data(u_data), .u_last(u_last), .u_valid(u_valid), .u_ready(u_ready),
    .v_data(v_data), .v_last(v_last), .v_valid(v_valid), .v_ready(v_ready),
    .w_data(w_data), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready)
`ifdef DEMUX_STREAM_COUNT_EN
    , .u_pkts(u_pkts), .v_pkts(v_pkts), .w_pkts(w_pkts)
`endif
  );

  function automatic int route_of(input logic a0, input logic a1);
    return a1 ? 2 : (a0 ? 1 : 0);
  endfunction

  function automatic logic [W+1:0] chan(input int c);
    case (c)
      0:       return {u_valid, u_last, u_data};
      1:       return {v_valid, v_last, v_data};
      default: return {w_valid, w_last, w_data};
    endcase
  endfunction

  // Per-cycle scoreboard check at the falling edge, then model update for
  // the rising edge that follows.
  task automatic monitor();
    logic [2:0]   vv, rr, ll;
    logic [W-1:0] dd [3];
    int           t;
    bit           exp_rdy;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vv = {w_valid, v_valid, u_valid};
        rr = {w_ready, v_ready, u_ready};
        ll = {w_last, v_last, u_last};
        dd[0] = u_data; dd[1] = v_data; dd[2] = w_data;
        for (int c = 0; c < 3; c++) begin
          vectors++;
          if (vv[c] !== (q[c].size() != 0)) begin
            miscompares++;
            $display("FAIL slot_valid ch%0d: got %b expected %b", c, vv[c], q[c].size() != 0);
          end else if (vv[c]) begin
            vectors++;
            if ({ll[c], dd[c]} !== q[c][0]) begin
              miscompares++;
              $display("FAIL slot_payload ch%0d: got %h expected %h", c, {ll[c], dd[c]}, q[c][0]);
            end
          end
`ifdef DEMUX_STREAM_COUNT_EN
          vectors++;
          if (((c == 0) ? u_pkts : (c == 1) ? v_pkts : w_pkts) !== cnt[c]) begin
            miscompares++;
            $display("FAIL pkt_count ch%0d: got %0d expected %0d", c,
                     (c == 0) ? u_pkts : (c == 1) ? v_pkts : w_pkts, cnt[c]);
          end
`endif
        end
        t = pkt_open ? pkt_ch : route_of(s0, s1);
        exp_rdy = !rst && (q[t].size() == 0 || rr[t]);
        vectors++;
        if (in_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL in_ready: got %b expected %b (target ch%0d)", in_ready, exp_rdy, t);
        end
        for (int c = 0; c < 3; c++) begin
          if (vv[c] && rr[c] && q[c].size() != 0) begin
`ifdef DEMUX_STREAM_COUNT_EN
            if (q[c][0][W]) cnt[c] = cnt[c] + 8'd1;
`endif
            void'(q[c].pop_front());
          end
        end
        if (rst) begin
          for (int c = 0; c < 3; c++) q[c].delete();
          pkt_open = 1'b0;
          pkt_ch = 0;
`ifdef DEMUX_STREAM_COUNT_EN
          for (int c = 0; c < 3; c++) cnt[c] = '0;
`endif
        end else if (in_valid && exp_rdy) begin
          q[t].push_back({in_last, in_data});
          pkt_open = !in_last;
          pkt_ch = t;
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        u_ready = ($urandom_range(0, 3) != 0);
        v_ready = ($urandom_range(0, 3) != 0);
        w_ready = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic a0,
                           input logic a1, output int waits);
    in_data = d; in_last = l; s0 = a0; s1 = a1; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: in_ready got 0 expected 1 after %0d cycles", waits);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; s0 = 1'b0; s1 = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      vectors++;
      if ({u_valid, v_valid, w_valid, u_last, v_last, w_last} !== 6'b0 ||
          {u_data, v_data, w_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_slots: got valid=%b%b%b data=%h/%h/%h expected all 0",
                 u_valid, v_valid, w_valid, u_data, v_data, w_data);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_accept: in_ready got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (chan(0) !== {1'b1, 1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL reset_first_beat: u got %h expected %h", chan(0), {1'b1, 1'b1, 8'h5A});
    end
  endtask

  task automatic test_route_decode();
    logic [W-1:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int           exp_ch [4] = '{0, 1, 2, 2};
    logic [1:0]   sel;
    int           wt;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      send_beat(dat[i], 1'b1, sel[0], sel[1], wt);
      vectors++;
      if (chan(exp_ch[i]) !== {1'b1, 1'b1, dat[i]}) begin
        miscompares++;
        $display("FAIL route_decode sel=%b: ch%0d got %h expected %h", sel, exp_ch[i],
                 chan(exp_ch[i]), {1'b1, 1'b1, dat[i]});
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_route_latch();
    int         wt;
    logic [1:0] sel;
    send_beat(8'hA0, 1'b0, 1'b1, 1'b0, wt);
    for (int i = 1; i < 4; i++) begin
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'b01) sel = 2'b10;
      send_beat(8'hA0 + W'(i), (i == 3), sel[0], sel[1], wt);
      vectors++;
      if (chan(1) !== {1'b1, (i == 3), 8'hA0 + W'(i)} || u_valid !== 1'b0 || w_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL route_latch beat %0d: v got %h expected %h, u_valid=%b w_valid=%b (expected 0)",
                 i, chan(1), {1'b1, (i == 3), 8'hA0 + W'(i)}, u_valid, w_valid);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int wt;
    v_ready = 1'b0;
    send_beat(8'hB0, 1'b0, 1'b1, 1'b0, wt);
    in_data = 8'hB1; in_last = 1'b0; s0 = 1'b0; s1 = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || chan(1) !== {1'b1, 1'b0, 8'hB0}) begin
        miscompares++;
        $display("FAIL backpressure_hold: in_ready=%b v=%h expected in_ready=0 v=%h",
                 in_ready, chan(1), {1'b1, 1'b0, 8'hB0});
      end
    end
    @(posedge clk);
    #1;
    v_ready = 1'b1;
    send_beat(8'hB1, 1'b0, 1'b0, 1'b1, wt);
    send_beat(8'hB2, 1'b1, 1'b1, 1'b1, wt);
    vectors++;
    if (wt !== 0 || chan(1) !== {1'b1, 1'b1, 8'hB2}) begin
      miscompares++;
      $display("FAIL backpressure_release: waits=%0d v=%h expected waits=0 v=%h",
               wt, chan(1), {1'b1, 1'b1, 8'hB2});
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_independent_drain();
    int           wt;
    logic [W-1:0] d;
    w_ready = 1'b0;
    send_beat(8'h77, 1'b1, 1'b0, 1'b1, wt);
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom);
      send_beat(d, (i == 2), 1'b0, 1'b0, wt);
      vectors++;
      if (wt !== 0 || chan(0) !== {1'b1, (i == 2), d} || chan(2) !== {1'b1, 1'b1, 8'h77}) begin
        miscompares++;
        $display("FAIL independent_drain beat %0d: waits=%0d u=%h w=%h expected waits=0 u=%h w=%h",
                 i, wt, chan(0), chan(2), {1'b1, (i == 2), d}, {1'b1, 1'b1, 8'h77});
      end
    end
    w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int wt;
    send_beat(8'hC0, 1'b0, 1'b0, 1'b1, wt);
    send_beat(8'hC1, 1'b0, 1'b0, 1'b1, wt);
    w_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    w_ready = 1'b1;
    vectors++;
    if ({u_valid, v_valid, w_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_reset_slots: valid u/v/w got %b%b%b expected 000", u_valid, v_valid, w_valid);
    end
    send_beat(8'hD0, 1'b1, 1'b0, 1'b0, wt);
    vectors++;
    if (chan(0) !== {1'b1, 1'b1, 8'hD0} || w_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_route: u=%h w_valid=%b expected u=%h w_valid=0",
               chan(0), w_valid, {1'b1, 1'b1, 8'hD0});
    end
`ifdef DEMUX_STREAM_COUNT_EN
    vectors++;
    if (w_pkts !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset_w_pkts: got %0d expected 0", w_pkts);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int         wt;
    logic [1:0] sel;
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = 2'($urandom_range(0, 3));
      send_beat(W'($urandom), ($urandom_range(0, 3) == 0), sel[0], sel[1], wt);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    u_ready = 1'b1; v_ready = 1'b1; w_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef DEMUX_STREAM_COUNT_EN
    for (int c = 0; c < 3; c++) cnt[c] = '0;
`endif
    fork
      monitor();
      ready_driver();
    join_none
    @(posedge clk);
    #1;
    test_reset();
    test_route_decode();
    test_route_latch();
    test_backpressure();
    test_independent_drain();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
